// File: rtl/tile_engine_if.sv
// Command, SRAM read/write and status signals between the NPU sequencer, the
// A/B/C scratchpads and the tile engine.
interface tile_engine_if #(
    parameter int DW     = 8,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [1:0]        op_code;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] c_base;
    logic [ADDR_W-1:0] row_stride;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DW-1:0]     a_dout;
    logic [DW-1:0]     b_dout;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DW-1:0]     c_din;
    logic              busy;
    logic              done;

    modport master (
        output start, op_code, a_base, b_base, c_base, row_stride, a_dout, b_dout,
        input  a_addr, b_addr, c_we, c_addr, c_din, busy, done
    );

    modport slave (
        input  start, op_code, a_base, b_base, c_base, row_stride, a_dout, b_dout,
        output a_addr, b_addr, c_we, c_addr, c_din, busy, done
    );
endinterface

// File: rtl/tile_engine.sv
// TILExTILE tile processor: loads A/B tiles from SRAM, runs ADD/SUB/MATMUL/DOT
// with wide signed accumulation, and streams the result tile into the C SRAM.
module tile_engine #(
    parameter int DW     = 8,
    parameter int TILE   = 4,
    parameter int ADDR_W = 10,
    parameter int SAT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    tile_engine_if.slave bus
);
    localparam int N     = TILE * TILE;
    localparam int ACC_W = 2 * DW + $clog2(N);
    localparam int CW    = $clog2(N + 2);
    localparam int IW    = $clog2(N);
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MATMUL = 2'd2, OP_DOT = 2'd3;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;

    state_t                   state_r, state_s;
    logic [CW-1:0]            cnt_r, cnt_s;
    logic [1:0]               op_r;
    logic [ADDR_W-1:0]        a_base_r, b_base_r, c_base_r, stride_r;
    logic signed [DW-1:0]     a_tile_r [N];
    logic signed [DW-1:0]     b_tile_r [N];
    logic signed [ACC_W-1:0]  acc_r [N];
    logic signed [ACC_W-1:0]  acc_s [N];
    logic signed [ACC_W-1:0]  dot_s;
    logic [ADDR_W-1:0]        a_addr_r, a_addr_s, b_addr_r, b_addr_s, c_addr_r, c_addr_s;
    logic [DW-1:0]            c_din_r, c_din_s;
    logic                     c_we_r, c_we_s, busy_r, busy_s, done_r, done_s;
    logic                     accept_s, capture_s, last_s;
    logic [IW-1:0]            k_s;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] stride,
                                                    input int idx);
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] c;
        r = ADDR_W'(idx / TILE);
        c = ADDR_W'(idx % TILE);
        return base + r * stride + c;
    endfunction

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [DW-1:0] x);
        return {{(ACC_W - DW){x[DW-1]}}, x};
    endfunction

    function automatic logic [DW-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (SAT != 0 && v > MAX_V) begin
            return MAX_V[DW-1:0];
        end else if (SAT != 0 && v < MIN_V) begin
            return MIN_V[DW-1:0];
        end else begin
            return v[DW-1:0];
        end
    endfunction

    assign bus.a_addr = a_addr_r;
    assign bus.b_addr = b_addr_r;
    assign bus.c_addr = c_addr_r;
    assign bus.c_din  = c_din_r;
    assign bus.c_we   = c_we_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

    // Next-state, next-output and arithmetic datapath.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        acc_s     = acc_r;
        dot_s     = '0;
        a_addr_s  = a_addr_r;
        b_addr_s  = b_addr_r;
        c_addr_s  = c_addr_r;
        c_din_s   = c_din_r;
        c_we_s    = 1'b0;
        busy_s    = 1'b1;
        done_s    = 1'b0;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        last_s    = 1'b0;
        k_s       = cnt_r[IW-1:0];
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (bus.start) begin
                    accept_s = 1'b1;
                    busy_s   = 1'b1;
                    state_s  = LOAD;
                    cnt_s    = '0;
                    a_addr_s = bus.a_base;
                    b_addr_s = bus.b_base;
                    for (int i = 0; i < N; i++) acc_s[i] = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                // Data for the address shown in count n arrives during count n+1.
                capture_s = (cnt_r != '0);
                if (int'(cnt_r) + 1 < N) begin
                    a_addr_s = tile_addr(a_base_r, stride_r, int'(cnt_r) + 1);
                    b_addr_s = tile_addr(b_base_r, stride_r, int'(cnt_r) + 1);
                end else begin
                    a_addr_s = a_addr_r;
                end
                if (cnt_r == CW'(N)) begin
                    state_s = COMPUTE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            COMPUTE: begin
                case (op_r)
                    OP_ADD: for (int i = 0; i < N; i++) acc_s[i] = sx(a_tile_r[i]) + sx(b_tile_r[i]);
                    OP_SUB: for (int i = 0; i < N; i++) acc_s[i] = sx(a_tile_r[i]) - sx(b_tile_r[i]);
                    OP_MATMUL: begin
                        for (int i = 0; i < TILE; i++) begin
                            for (int j = 0; j < TILE; j++) begin
                                acc_s[i*TILE+j] = acc_r[i*TILE+j]
                                    + sx(a_tile_r[IW'(i * TILE) + k_s])
                                    * sx(b_tile_r[k_s * IW'(TILE) + IW'(j)]);
                            end
                        end
                    end
                    OP_DOT: begin
                        for (int c = 0; c < TILE; c++) begin
                            dot_s = dot_s + sx(a_tile_r[k_s * IW'(TILE) + IW'(c)])
                                          * sx(b_tile_r[k_s * IW'(TILE) + IW'(c)]);
                        end
                        acc_s[0] = acc_r[0] + dot_s;
                    end
                    default: acc_s = acc_r;
                endcase
                last_s = (op_r == OP_ADD) || (op_r == OP_SUB) || (cnt_r == CW'(TILE - 1));
                if (last_s) begin
                    state_s  = WRITE;
                    cnt_s    = '0;
                    c_we_s   = 1'b1;
                    c_addr_s = c_base_r;
                    c_din_s  = clamp(acc_s[0]);
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            WRITE: begin
                last_s = (op_r == OP_DOT) ? (cnt_r == '0) : (cnt_r == CW'(N - 1));
                if (last_s) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                end else begin
                    cnt_s    = cnt_r + CW'(1);
                    c_we_s   = 1'b1;
                    c_addr_s = tile_addr(c_base_r, stride_r, int'(cnt_r) + 1);
                    c_din_s  = clamp(acc_r[k_s + IW'(1)]);
                end
            end
            DONE: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, command capture, tile capture, accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            op_r     <= 2'd0;
            a_base_r <= '0;
            b_base_r <= '0;
            c_base_r <= '0;
            stride_r <= '0;
            a_addr_r <= '0;
            b_addr_r <= '0;
            c_addr_r <= '0;
            c_din_r  <= '0;
            c_we_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_tile_r[i] <= '0;
                b_tile_r[i] <= '0;
                acc_r[i]    <= '0;
            end
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            a_addr_r <= a_addr_s;
            b_addr_r <= b_addr_s;
            c_addr_r <= c_addr_s;
            c_din_r  <= c_din_s;
            c_we_r   <= c_we_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            for (int i = 0; i < N; i++) acc_r[i] <= acc_s[i];
            if (accept_s) begin
                op_r     <= bus.op_code;
                a_base_r <= bus.a_base;
                b_base_r <= bus.b_base;
                c_base_r <= bus.c_base;
                stride_r <= bus.row_stride;
            end
            if (capture_s) begin
                a_tile_r[k_s - IW'(1)] <= $signed(bus.a_dout);
                b_tile_r[k_s - IW'(1)] <= $signed(bus.b_dout);
            end
        end
    end
endmodule
